arb_mux_stage: RTL

Two-source, 32-bit arbitrated pipeline stage wrapped around the team's 2:1 word mux (basemux).
- Accepts two valid/ready input streams (A, B).
- Picks one by round-robin and drives the mux select.
- Registers the mux output into a single-entry output stage with valid/ready toward the consumer.
- Sits directly in front of any consumer of basemux output and replaces ad-hoc select driving.

---
 rtl/arb_mux_pkg.sv | 20 ++
 rtl/basemux.sv | 25 ++
 rtl/arb_mux_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/arb_mux_pkg.sv
// ============================================================================
// Module      : arb_mux_pkg
// Description : Shared constants for the arbitrated mux stage.
//               - SEL_A / SEL_B : basemux select encoding (1 = A, 0 = B).
//               - Default data and grant-counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_mux_pkg;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 16;

endpackage : arb_mux_pkg

`default_nettype wire

// File: rtl/basemux.sv
// ============================================================================
// Module      : basemux
// Description : 2:1 word multiplexer.
//               Ports: a, b (WIDTH) data inputs; sel (1 = a, 0 = b);
//                      y (WIDTH) selected word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module basemux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = (sel == SEL_A) ? a : b;

endmodule : basemux

`default_nettype wire

// File: rtl/arb_mux_stage.sv
// ============================================================================
// Module      : arb_mux_stage
// Description : Two-source round-robin arbiter driving basemux, followed by a
//               single-entry registered output stage with valid/ready.
//               Ports:
//                 clk, rst_n              clock, async active-low reset
//                 a_data/a_valid/a_ready  source A stream
//                 b_data/b_valid/b_ready  source B stream
//                 out_data/out_valid/out_ready  consumer stream
//                 sel                     mux select (1 = A, 0 = B)
//               Optional build macro ARB_MUX_STAGE_STATS_EN adds saturating
//               grant counters grant_cnt_a / grant_cnt_b (CNT_W bits each).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_mux_stage
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ARB_MUX_STAGE_STATS_EN
    output logic [CNT_W-1:0] grant_cnt_a,
    output logic [CNT_W-1:0] grant_cnt_b,
`endif
    output logic             sel
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_last_grant;
    logic             w_load;
    logic             w_sel;
    logic             w_xfer;
    logic [WIDTH-1:0] w_mux_y;

    // The stage can take a word when empty or when its word leaves this cycle.
    assign w_load = !r_out_valid || out_ready;

    // Round-robin: a lone requester wins; on a tie the source not granted
    // last time wins; with no requester the select parks on the last grant.
    always_comb begin
        w_sel = r_last_grant;
        unique case ({a_valid, b_valid})
            2'b10:   w_sel = SEL_A;
            2'b01:   w_sel = SEL_B;
            2'b11:   w_sel = !r_last_grant;
            default: w_sel = r_last_grant;
        endcase
    end

    assign w_xfer  = w_load && (a_valid || b_valid);
    assign a_ready = w_load && (w_sel == SEL_A);
    assign b_ready = w_load && (w_sel == SEL_B);
    assign sel     = w_sel;

    basemux #(
        .WIDTH (WIDTH)
    ) u_basemux (
        .a   (a_data),
        .b   (b_data),
        .sel (w_sel),
        .y   (w_mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_last_grant <= SEL_B;
        end else if (w_xfer) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_mux_y;
            r_last_grant <= w_sel;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef ARB_MUX_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (w_xfer) begin
            if (w_sel == SEL_A && r_cnt_a != '1) begin
                r_cnt_a <= r_cnt_a + c_cnt_one;
            end
            if (w_sel == SEL_B && r_cnt_b != '1) begin
                r_cnt_b <= r_cnt_b + c_cnt_one;
            end
        end
    end

    assign grant_cnt_a = r_cnt_a;
    assign grant_cnt_b = r_cnt_b;
`else
    // Keeps CNT_W referenced when the counters are compiled out.
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule : arb_mux_stage

`default_nettype wire
